pulse_injector: RTL
===================

Name: pulse_injector

Overview:
- Synthetic detector-pulse source for the 14-bit sample path.
- Produces a baseline + shaped-pulse sample stream plus a gate marking the pulse samples. It is the transmit-side counterpart of the trigger-gated integrator: `data_out`/`gate_out` drive the integrator's `data_in`/`trig_in` in loopback self-test.
- Also reports the exact gated sample sum, so charge readout can be checked end to end without the ADC.

Parameters:
- DATA_W, 14, sample width.
- BASELINE, 200, idle pedestal value output between pulses.
- RISE_SHIFT, 2, rise length = 2^RISE_SHIFT samples.
- DECAY_SHIFT, 2, exponential decay factor per sample: e -= e>>DECAY_SHIFT.
- SUM_W, 30, expected_sum width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  pulse request; accepted only when busy=0
- abort  input  1  terminate current pulse; return to IDLE
- amplitude  input  DATA_W  pulse height above baseline; sampled on accept
- width  input  8  flat-top length in samples; sampled on accept
- data_out  output  DATA_W  sample stream (registered)
- gate_out  output  1  high on every pulse sample (registered)
- busy  output  1  pulse in progress
- done  output  1  one-cycle strobe after the last pulse sample of a completed pulse
- expected_sum  output  SUM_W  sum of data_out over gated samples of the last pulse
- pulse_count  output  16  completed pulses, wraps 65535->0

Behaviour:
- Reset (async): state=IDLE, data_out=BASELINE, gate_out=0, busy=0, done=0, expected_sum=0, pulse_count=0.
- States: IDLE, RISE, FLAT, DECAY. All outputs are registered. e is the internal excess above baseline.

Accept (IDLE and start=1):
- Latch A = min(amplitude, 2^DATA_W-1-BASELINE).
- Latch W = width; width=0 is treated as 1.
- Clear expected_sum; enter RISE; busy=1 from the next cycle.
- First gated sample appears the cycle after accept (latency 1).
- start while busy is ignored. start in the done cycle is accepted (back-to-back pulses, no gap sample required).

RISE:
- 2^RISE_SHIFT samples, k=0..2^RISE_SHIFT-1.
- e = (A*(k+1))>>RISE_SHIFT; the product is computed at DATA_W+RISE_SHIFT bits with no truncation before the shift.
- The last rise sample equals A.

FLAT:
- W samples, e=A.

DECAY:
- First decay sample e0 = A-(A>>DECAY_SHIFT).
- Each cycle outputs BASELINE+e. If (e>>DECAY_SHIFT)==0, this is the last sample; otherwise e <= e-(e>>DECAY_SHIFT).
- Every decay sample is gated, including the last.

Outputs and completion:
- During all gated samples: data_out = BASELINE+e, never exceeding 2^DATA_W-1 (guaranteed by the clip on A).
- expected_sum accumulates each gated data_out value, including baseline, at full SUM_W width.
- The cycle after the last gated sample:
  - state=IDLE, gate_out=0, data_out=BASELINE, busy=0.
  - done=1 for one cycle; pulse_count increments.
  - expected_sum is stable from then until the next accept.

abort:
- If asserted while busy, the next cycle returns to IDLE: gate_out=0, data_out=BASELINE, busy=0.
- No done strobe, pulse_count unchanged, expected_sum holds the partial sum.
- abort in IDLE has no effect.
- abort together with start in IDLE: abort wins, no accept.

Reset mid-pulse: all outputs return to reset values immediately; no done strobe.

Test Plan:
Defaults BASELINE=200, RISE_SHIFT=2, DECAY_SHIFT=2.
1. amplitude=400, width=3, start 1 cycle
   -> gated data_out = 300,400,500,600 (rise), 600×3 (flat), then 500,425,369,327,296,272,254,241,231,224,218,214,211,209,207,206,205,204,203 (decay).
   -> 26 gated cycles; done 1 cycle later; expected_sum=8616; pulse_count=1.
2. amplitude=0, width=0
   -> 6 gated samples all 200 (4 rise, 1 flat, 1 decay); expected_sum=1200; done asserted.
3. amplitude=16383, width=2
   -> A clipped to 16183; flat samples=16383; the last rise sample=16383; no wrap anywhere.
4. start held high continuously with amplitude=400, width=3
   -> extra starts ignored while busy; the next pulse's first gated sample is the cycle after done; two consecutive expected_sum=8616; pulse_count=2.
5. abort in the 2nd flat cycle of scenario 1
   -> next cycle gate_out=0, data_out=200, busy=0; no done; pulse_count unchanged; expected_sum=1000+800+1200=3000 (4 rise + 2 flat gated samples incl. baseline).
6. rst asserted mid-decay
   -> asynchronous clear to reset values; a new start afterwards reproduces scenario 1 exactly.

Source files
------------

// File: rtl/pulse_injector.sv
// Synthetic detector-pulse source: baseline plus linear-rise / flat-top /
// exponential-decay pulse, with a gate and the exact gated sample sum.
module pulse_injector #(
  parameter int DATA_W      = 14,
  parameter int BASELINE    = 200,
  parameter int RISE_SHIFT  = 2,
  parameter int DECAY_SHIFT = 2,
  parameter int SUM_W       = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] amplitude,
  input  logic [7:0]        width,
  output logic [DATA_W-1:0] data_out,
  output logic              gate_out,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  expected_sum,
  output logic [15:0]       pulse_count
);

  typedef enum logic [1:0] {IDLE, RISE, FLAT, DECAY} state_t;

  localparam int PW = DATA_W + RISE_SHIFT + 1;
  localparam logic [DATA_W-1:0]   A_MAX  = DATA_W'((2**DATA_W) - 1 - BASELINE);
  localparam logic [DATA_W-1:0]   BASE   = DATA_W'(BASELINE);
  localparam logic [RISE_SHIFT:0] K_LAST = (RISE_SHIFT+1)'((2**RISE_SHIFT) - 1);

  // Product kept wide so the ramp is exact before the shift.
  function automatic logic [DATA_W-1:0] rise_e(input logic [DATA_W-1:0] a,
                                               input logic [RISE_SHIFT:0] k);
    logic [PW-1:0] p;
    p = PW'(a) * (PW'(k) + PW'(1));
    return DATA_W'(p >> RISE_SHIFT);
  endfunction

  state_t            state_q, state_d;
  logic [RISE_SHIFT:0] k_q, k_d;
  logic [7:0]        cnt_q, cnt_d, w_q, w_d;
  logic [DATA_W-1:0] a_q, a_d, e_q, e_d, data_q, data_d, a_clip;
  logic              gate_q, gate_d, busy_q, busy_d, done_q, done_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [15:0]       count_q, count_d;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    w_d     = w_q;
    e_d     = e_q;
    gate_d  = 1'b0;
    done_d  = 1'b0;
    count_d = count_q;
    // The sum trails the sample stream by one cycle, so it is final in the done cycle.
    sum_d   = gate_q ? sum_q + SUM_W'(data_q) : sum_q;
    a_clip  = (amplitude > A_MAX) ? A_MAX : amplitude;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          a_d     = a_clip;
          w_d     = (width == 8'd0) ? 8'd1 : width;
          k_d     = '0;
          e_d     = rise_e(a_clip, '0);
          state_d = RISE;
          gate_d  = 1'b1;
          sum_d   = '0;
        end
      end
      RISE: begin
        gate_d = 1'b1;
        if (k_q == K_LAST) begin
          state_d = FLAT;
          cnt_d   = 8'd1;
          e_d     = a_q;
        end else begin
          k_d = k_q + (RISE_SHIFT+1)'(1);
          e_d = rise_e(a_q, k_q + (RISE_SHIFT+1)'(1));
        end
      end
      FLAT: begin
        gate_d = 1'b1;
        if (cnt_q == w_q) begin
          state_d = DECAY;
          e_d     = a_q - (a_q >> DECAY_SHIFT);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DECAY: begin
        if ((e_q >> DECAY_SHIFT) == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          count_d = count_q + 16'd1;
        end else begin
          e_d    = e_q - (e_q >> DECAY_SHIFT);
          gate_d = 1'b1;
        end
      end
    endcase

    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      gate_d  = 1'b0;
      done_d  = 1'b0;
      count_d = count_q;
    end

    data_d = gate_d ? BASE + e_d : BASE;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      w_q     <= '0;
      e_q     <= '0;
      data_q  <= BASE;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      w_q     <= w_d;
      e_q     <= e_d;
      data_q  <= data_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

  assign data_out     = data_q;
  assign gate_out     = gate_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign expected_sum = sum_q;
  assign pulse_count  = count_q;

endmodule
